// File: rtl/serial_word_tx_pkg.sv
// serial_pkg: shared state encoding and receiver shift-command constants
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [1:0] SH_HOLD  = 2'b00;
  localparam logic [1:0] SH_RIGHT = 2'b01;
  localparam logic [1:0] SH_LEFT  = 2'b10;
  localparam logic [1:0] SH_LOAD  = 2'b11;
endpackage

// File: rtl/serial_word_tx_if.sv
// serial_word_tx_if: word handshake between the datapath controller and the transmitter
interface serial_word_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data_in;
  logic data_valid;
  logic data_ready;
  logic msb_first;
  modport master(output data_in, data_valid, msb_first, input data_ready);
  modport slave(input data_in, data_valid, msb_first, output data_ready);
endinterface

// File: rtl/serial_word_tx_bit_counter.sv
// tx_bit_counter: loadable down-counter flagging the last bit of a frame
module tx_bit_counter #(parameter int CNT_W = 4) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clr,
  input  logic dec,
  input  logic [CNT_W-1:0] load_val,
  output logic last
);
  logic [CNT_W-1:0] cnt;
  assign last = cnt <= CNT_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/serial_word_tx.sv
// serial_word_tx: handshaked parallel-to-serial transmitter with receiver shift commands
module serial_word_tx
  import serial_pkg::*;
#(parameter int WIDTH = 8) (
  input  logic clk,
  input  logic reset,
  serial_word_tx_if.slave prod,
  input  logic abort,
  output logic sout,
  output logic sout_valid,
  output logic [1:0] shift_cmd,
  output logic done,
  output logic busy
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] shreg, nxt;
  logic dir, last, take, kill;
  assign take = state == IDLE && prod.data_valid && prod.data_ready && !abort;
  assign kill = abort && state != IDLE;
  assign nxt = dir ? shreg << 1 : shreg >> 1;
  tx_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .reset(reset),
    .load(take),
    .clr(kill),
    .dec(state == SHIFT),
    .load_val(CNT_W'(WIDTH)),
    .last(last)
  );
  // outputs are loaded one edge early so each bit is on the line in the cycle its state holds
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      dir <= 1'b0;
      sout <= 1'b0;
      sout_valid <= 1'b0;
      shift_cmd <= SH_HOLD;
      done <= 1'b0;
      busy <= 1'b0;
      prod.data_ready <= 1'b1;
    end else if (kill) begin
      state <= IDLE;
      shreg <= '0;
      dir <= 1'b0;
      sout <= 1'b0;
      sout_valid <= 1'b0;
      shift_cmd <= SH_HOLD;
      done <= 1'b0;
      busy <= 1'b0;
      prod.data_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (take) begin
          state <= SHIFT;
          shreg <= prod.data_in;
          dir <= prod.msb_first;
          sout <= prod.msb_first ? prod.data_in[WIDTH-1] : prod.data_in[0];
          sout_valid <= 1'b1;
          shift_cmd <= prod.msb_first ? SH_LEFT : SH_RIGHT;
          busy <= 1'b1;
          prod.data_ready <= 1'b0;
        end
        SHIFT: begin
          shreg <= nxt;
          sout <= last ? 1'b0 : (dir ? nxt[WIDTH-1] : nxt[0]);
          sout_valid <= !last;
          shift_cmd <= last ? SH_HOLD : shift_cmd;
          done <= last;
          state <= last ? DONE : SHIFT;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          prod.data_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed vectors with a behavioural receiver register on the serial line
module tb_serial_word_tx;
  import serial_pkg::*;
  logic clk = 0, reset = 0, abort = 0;
  logic sout, sout_valid, done, busy;
  logic [1:0] shift_cmd;
  logic [7:0] rx_q = '0;
  int total = 0, passed = 0;
  serial_word_tx_if #(.WIDTH(8)) bus();
  serial_word_tx #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .prod(bus), .abort(abort),
    .sout(sout), .sout_valid(sout_valid), .shift_cmd(shift_cmd), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  // receiver register: samples sout on the edge that applies shift_cmd
  always @(posedge clk)
    rx_q <= shift_cmd == SH_RIGHT ? {sout, rx_q[7:1]} : shift_cmd == SH_LEFT ? {rx_q[6:0], sout} : rx_q;
  typedef struct {
    logic [7:0] data;
    logic msb;
    logic [7:0] seq;
    logic [1:0] cmd;
  } vec_t;
  vec_t vecs[6];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!bus.data_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", bus.data_ready, 1);
  endtask
  task automatic check_idle(input string n);
    chk({n, "_sout"}, sout, 0);
    chk({n, "_sout_valid"}, sout_valid, 0);
    chk({n, "_shift_cmd"}, shift_cmd, SH_HOLD);
    chk({n, "_done"}, done, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_data_ready"}, bus.data_ready, 1);
  endtask
  task automatic send(input vec_t v);
    wait_ready();
    bus.data_in = v.data;
    bus.msb_first = v.msb;
    bus.data_valid = 1;
    tick();
    bus.data_valid = 0;
    bus.data_in = ~v.data;
    bus.msb_first = ~v.msb;
    for (int i = 0; i < 8; i++) begin
      chk("sout", sout, v.seq[i]);
      chk("sout_valid", sout_valid, 1);
      chk("shift_cmd", shift_cmd, v.cmd);
      chk("ready_while_busy", bus.data_ready, 0);
      chk("busy", busy, 1);
      bus.data_valid = (i == 3);
      tick();
    end
    bus.data_valid = 0;
    chk("done_pulse", done, 1);
    chk("done_sout_valid", sout_valid, 0);
    chk("done_shift_cmd", shift_cmd, SH_HOLD);
    chk("done_ready", bus.data_ready, 0);
    chk("rx_word", rx_q, v.data);
    tick();
    chk("done_drop", done, 0);
    chk("ready_back", bus.data_ready, 1);
    chk("busy_drop", busy, 0);
  endtask
  initial begin
    int last_acc, n_acc, seen;
    vecs[0] = '{8'hA5, 1'b0, 8'hA5, SH_RIGHT};
    vecs[1] = '{8'h3C, 1'b1, 8'h3C, SH_LEFT};
    vecs[2] = '{8'h00, 1'b0, 8'h00, SH_RIGHT};
    vecs[3] = '{8'hFF, 1'b0, 8'hFF, SH_RIGHT};
    vecs[4] = '{8'h81, 1'b0, 8'h81, SH_RIGHT};
    vecs[5] = '{8'h12, 1'b1, 8'h48, SH_LEFT};
    bus.data_in = '0;
    bus.data_valid = 0;
    bus.msb_first = 0;
    #1 reset = 1;
    #2 check_idle("reset");
    tick();
    tick();
    reset = 0;
    check_idle("post_reset");
    for (int k = 0; k < 6; k++) send(vecs[k]);
    // abort after the third bit of F0
    wait_ready();
    bus.data_in = 8'hF0;
    bus.msb_first = 0;
    bus.data_valid = 1;
    tick();
    bus.data_valid = 0;
    tick();
    tick();
    chk("abort_bit3", sout, 0);
    chk("abort_bit3_valid", sout_valid, 1);
    abort = 1;
    tick();
    abort = 0;
    check_idle("abort");
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      seen += int'(done);
      tick();
    end
    chk("no_done_after_abort", seen, 0);
    // abort wins over a handshake in IDLE
    abort = 1;
    bus.data_valid = 1;
    tick();
    abort = 0;
    bus.data_valid = 0;
    check_idle("abort_idle");
    // async reset between edges mid-frame
    bus.data_in = 8'h5A;
    bus.data_valid = 1;
    tick();
    bus.data_valid = 0;
    tick();
    tick();
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1;
    #1 check_idle("async_reset");
    tick();
    reset = 0;
    send('{8'h5A, 1'b0, 8'h5A, SH_RIGHT});
    // data_valid held high: acceptances every WIDTH+2 cycles
    bus.data_in = 8'h77;
    bus.msb_first = 0;
    bus.data_valid = 1;
    last_acc = -1;
    n_acc = 0;
    for (int c = 0; c < 35; c++) begin
      if (bus.data_ready) begin
        if (last_acc >= 0) chk("accept_gap", c - last_acc, 10);
        last_acc = c;
        n_acc++;
      end
      if (busy && bus.data_ready) chk("ready_and_busy", 1, 0);
      tick();
    end
    bus.data_valid = 0;
    chk("accept_count", n_acc, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter. It is the sending end for the 8-bit shift register, which captures one bit per cycle on its serial input Din.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per cycle.
- Drives the serial line, a matching 2-bit shift command for the receiving register, and a completion pulse.
- Sits between the datapath controller (word producer) and the serial shift register (word consumer).

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- data_in, input, WIDTH, word to transmit; sampled only on handshake.
- data_valid, input, 1, producer has a word.
- data_ready, output, 1, transmitter can accept a word (IDLE only).
- msb_first, input, 1, sampled on handshake. 0 = LSB first, which feeds a right-shifting receiver (shift=01). 1 = MSB first, which feeds a left-shifting receiver (shift=10).
- abort, input, 1, synchronous cancel of the current frame.
- sout, output, 1, serial data bit.
- sout_valid, output, 1, sout carries a frame bit this cycle.
- shift_cmd, output, 2, command for the receiving register: 00 hold, 01 right shift, 10 left shift; 11 never driven.
- done, output, 1, one-cycle pulse after the last bit.
- busy, output, 1, high while not IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, shreg=0, cnt=0, dir=0. Outputs: sout=0, sout_valid=0, shift_cmd=00, done=0, busy=0, data_ready=1.
- All outputs are registered; none is combinational from inputs.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - data_ready=1.
  - On data_valid&data_ready: shreg<=data_in, dir<=msb_first, cnt<=WIDTH, state<=SHIFT.
  - data_valid without a handshake is ignored. data_in may change freely outside the handshake.
- SHIFT, one bit per cycle:
  - sout = shreg[0] when dir=0, shreg[WIDTH-1] when dir=1.
  - sout_valid=1; shift_cmd = 01 (dir=0) or 10 (dir=1).
  - shreg shifts toward the emitting end and zero-fills.
  - cnt decrements. When cnt reaches 1 (last bit emitted), state<=DONE.
- DONE: done=1 for exactly one cycle; sout_valid=0, shift_cmd=00; state<=IDLE.
- Latency: handshake in cycle N.
  - First bit valid in cycle N+1.
  - Last bit in cycle N+WIDTH.
  - done in cycle N+WIDTH+1.
  - data_ready high again in cycle N+WIDTH+2.
- Throughput: one word per WIDTH+2 cycles. No back-to-back acceptance.
- Receiver alignment: the receiver samples sout on the same edge at which it applies shift_cmd. After WIDTH shifts the receiver holds the original word unchanged.
- abort:
  - In SHIFT or DONE: next state IDLE, shreg cleared, done not asserted, sout_valid and shift_cmd drop to 0/00 the following cycle.
  - In IDLE: no effect.
  - abort and data_valid together in IDLE: abort wins and no handshake occurs.
- Reset mid-frame: immediate return to the reset values; the partial frame is lost and no done pulse is produced.
- Inputs during SHIFT/DONE: changes to data_in, data_valid and msb_first have no effect.
- cnt never wraps. Reaching SHIFT with cnt=0 is unreachable; if it occurs, the block treats it as the last bit.

Decomposition:
- Shared package, serial_pkg:
  - State enum: IDLE, SHIFT, DONE.
  - Shift-command constants: SH_HOLD=2'b00, SH_RIGHT=2'b01, SH_LEFT=2'b10, SH_LOAD=2'b11. These match the receiving register's mux encoding.
- One natural sub-module: tx_bit_counter, a loadable down-counter with a last-bit flag.
- The shift register and FSM stay in the top module.

Test Plan:
- LSB first: data_in=8'hA5, msb_first=0, handshake at cycle 0.
  - sout over cycles 1..8 = 1,0,1,0,0,1,0,1.
  - shift_cmd=01 throughout; done=1 at cycle 9; data_ready=1 at cycle 10.
- MSB first: data_in=8'h3C, msb_first=1.
  - sout = 0,0,1,1,1,1,0,0; shift_cmd=10.
  - A connected receiver register reads 8'h3C after done.
- Loopback into the receiver register, right shift, words 8'h00, 8'hFF, 8'h81 in sequence: receiver Q equals each word at its done pulse, and no handshake occurs while busy=1.
- Abort after the 3rd bit of 8'hF0: next cycle sout_valid=0 and shift_cmd=00, no done pulse, data_ready=1.
- Async reset asserted mid-frame (between clock edges): all outputs go to reset values immediately; after release, a new word 8'h5A transmits correctly.
- data_valid held high continuously: words are accepted only in IDLE, spaced exactly WIDTH+2=10 cycles apart.
